// File: rtl/snn_pkg.sv
// Shared definitions for the SNN stimulus driver.
//   - state_t      : driver FSM states
//   - ERR_*        : err_code values reported with done
//   - *_DEF        : default pattern geometry and latency budget
package snn_pkg;

    localparam int IMG_LEN_DEF = 72;
    localparam int KER_LEN_DEF = 27;
    localparam int WGT_LEN_DEF = 4;
    localparam int LAT_MAX_DEF = 1000;
    localparam int LAT_W_DEF   = 10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_REPORT = 2'd3
    } state_t;

    localparam logic [1:0] ERR_OK       = 2'd0;
    localparam logic [1:0] ERR_MISMATCH = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
    localparam logic [1:0] ERR_PROTOCOL = 2'd3;

endpackage

// File: rtl/snn_lat_timer.sv
// Latency counter for the wait-for-result phase.
//   clk, rst_n : clock, synchronous active-low reset
//   load       : set count to 1 (first cycle after the last in_valid)
//   en         : increment count
//   count      : cycles since the last in_valid cycle
//   timeout    : count has reached LAT_MAX
module snn_lat_timer #(
    parameter int LAT_MAX = 1000,
    parameter int LAT_W   = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    output logic [LAT_W-1:0] count,
    output logic             timeout
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= LAT_W'(1);
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign timeout = (count == LAT_W'(LAT_MAX));

endmodule

// File: rtl/snn_stim_driver.sv
// Initiator for the SNN input/output protocol (self-test / bring-up).
// On start it streams IMG_LEN words from a combinational stimulus ROM onto
// in_valid/Img/Kernel/Weight/Opt, waits for out_valid, captures out,
// measures latency and reports pass/fail with a one-cycle done pulse.
//   start, cfg_opt, cfg_cg_en, exp_out : pattern request and its settings
//   src_addr / src_img, src_ker, src_wgt : stimulus ROM port
//   cg_en, in_valid, Img, Kernel, Weight, Opt : registered outputs to the SNN
//   out_valid, out : result from the SNN
//   busy, done, pass, err_code, result, latency : status
//
// Handshake: the SNN takes one word on every cycle in_valid is high (no
// backpressure); it answers with a single-cycle out_valid carrying out.
module snn_stim_driver
    import snn_pkg::*;
#(
    parameter int IMG_LEN = IMG_LEN_DEF,
    parameter int KER_LEN = KER_LEN_DEF,
    parameter int WGT_LEN = WGT_LEN_DEF,
    parameter int LAT_MAX = LAT_MAX_DEF,
    parameter int LAT_W   = LAT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       cfg_opt,
    input  logic             cfg_cg_en,
    input  logic [31:0]      exp_out,
    output logic [6:0]       src_addr,
    input  logic [31:0]      src_img,
    input  logic [31:0]      src_ker,
    input  logic [31:0]      src_wgt,
    output logic             cg_en,
    output logic             in_valid,
    output logic [31:0]      Img,
    output logic [31:0]      Kernel,
    output logic [31:0]      Weight,
    output logic [1:0]       Opt,
    input  logic             out_valid,
    input  logic [31:0]      out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [1:0]       err_code,
    output logic [31:0]      result,
    output logic [LAT_W-1:0] latency
);

    localparam logic [6:0] LAST_K = 7'(IMG_LEN - 1);

    state_t           state;
    logic [6:0]       k;          // index of the word currently on Img
    logic [31:0]      exp_q;
    logic             timer_load;
    logic             timer_en;
    logic [LAT_W-1:0] lat_count;
    logic             lat_timeout;

    // Counter is loaded with 1 on the edge leaving the last in_valid cycle,
    // so it reads 1 in the first WAIT cycle.
    assign timer_load = (state == ST_DRIVE) && (k == LAST_K);
    assign timer_en   = (state == ST_WAIT) && !out_valid && !lat_timeout;

    snn_lat_timer #(
        .LAT_MAX (LAT_MAX),
        .LAT_W   (LAT_W)
    ) u_lat_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (timer_load),
        .en      (timer_en),
        .count   (lat_count),
        .timeout (lat_timeout)
    );

    // src_addr sits at 0 while idle, so the word for k=0 is already on the
    // ROM output when start arrives and in_valid can rise on the next cycle.
    // From then on src_addr is one ahead of the word being shown.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            k        <= '0;
            exp_q    <= '0;
            src_addr <= '0;
            cg_en    <= 1'b0;
            in_valid <= 1'b0;
            Img      <= '0;
            Kernel   <= '0;
            Weight   <= '0;
            Opt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_code <= ERR_OK;
            result   <= '0;
            latency  <= '0;
        end else begin
            done <= 1'b0;
            pass <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_DRIVE;
                        busy     <= 1'b1;
                        cg_en    <= cfg_cg_en;
                        exp_q    <= exp_out;
                        err_code <= ERR_OK;
                        result   <= '0;
                        latency  <= '0;
                        k        <= '0;
                        src_addr <= (IMG_LEN > 1) ? 7'd1 : 7'd0;
                        in_valid <= 1'b1;
                        Img      <= src_img;
                        Kernel   <= (KER_LEN > 0) ? src_ker : 32'd0;
                        Weight   <= (WGT_LEN > 0) ? src_wgt : 32'd0;
                        Opt      <= cfg_opt;
                    end
                end

                ST_DRIVE: begin
                    Opt <= '0;
                    // Early out_valid is flagged but the stream is finished.
                    if (out_valid) begin
                        err_code <= ERR_PROTOCOL;
                    end
                    if (k == LAST_K) begin
                        in_valid <= 1'b0;
                        Img      <= '0;
                        Kernel   <= '0;
                        Weight   <= '0;
                        src_addr <= '0;
                        if (out_valid || (err_code == ERR_PROTOCOL)) begin
                            state <= ST_REPORT;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end else begin
                        k        <= k + 1'b1;
                        Img      <= src_img;
                        Kernel   <= (int'(k) + 1 < KER_LEN) ? src_ker : 32'd0;
                        Weight   <= (int'(k) + 1 < WGT_LEN) ? src_wgt : 32'd0;
                        src_addr <= (int'(k) + 2 >= IMG_LEN) ? 7'd0 : src_addr + 1'b1;
                    end
                end

                ST_WAIT: begin
                    // A result arriving on the timeout cycle still counts.
                    if (out_valid) begin
                        state   <= ST_REPORT;
                        done    <= 1'b1;
                        result  <= out;
                        latency <= lat_count;
                        if (out == exp_q) begin
                            pass <= 1'b1;
                        end else begin
                            err_code <= ERR_MISMATCH;
                        end
                    end else if (lat_timeout) begin
                        state    <= ST_REPORT;
                        done     <= 1'b1;
                        err_code <= ERR_TIMEOUT;
                    end
                end

                ST_REPORT: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    cg_en <= 1'b0;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snn_stim_driver.sv
// Bench for snn_stim_driver: stimulus ROM, behavioural SNN responder,
// per-cycle stream monitor and end-of-pattern report checks.
module tb_snn_stim_driver;

    localparam int IMG_LEN = 72;
    localparam int KER_LEN = 27;
    localparam int WGT_LEN = 4;
    localparam int LAT_MAX = 1000;
    localparam int LAT_W   = 10;

    // Responder modes
    localparam int RESP_NONE  = 0;  // never answer
    localparam int RESP_DELAY = 1;  // answer resp_param cycles after last in_valid
    localparam int RESP_EARLY = 2;  // pulse during stream cycle resp_param

    // clock / reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // DUT signals
    logic             start;
    logic [1:0]       cfg_opt;
    logic             cfg_cg_en;
    logic [31:0]      exp_out;
    logic [6:0]       src_addr;
    logic [31:0]      src_img, src_ker, src_wgt;
    logic             cg_en, in_valid;
    logic [31:0]      Img, Kernel, Weight;
    logic [1:0]       Opt;
    logic             out_valid;
    logic [31:0]      out_data;
    logic             busy, done, pass;
    logic [1:0]       err_code;
    logic [31:0]      result;
    logic [LAT_W-1:0] latency;

    snn_stim_driver dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .cfg_opt   (cfg_opt),
        .cfg_cg_en (cfg_cg_en),
        .exp_out   (exp_out),
        .src_addr  (src_addr),
        .src_img   (src_img),
        .src_ker   (src_ker),
        .src_wgt   (src_wgt),
        .cg_en     (cg_en),
        .in_valid  (in_valid),
        .Img       (Img),
        .Kernel    (Kernel),
        .Weight    (Weight),
        .Opt       (Opt),
        .out_valid (out_valid),
        .out       (out_data),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_code  (err_code),
        .result    (result),
        .latency   (latency)
    );

    // stimulus ROM
    logic [31:0] rom_img [IMG_LEN];
    logic [31:0] rom_ker [IMG_LEN];
    logic [31:0] rom_wgt [IMG_LEN];
    assign src_img = (int'(src_addr) < IMG_LEN) ? rom_img[src_addr] : 32'd0;
    assign src_ker = (int'(src_addr) < IMG_LEN) ? rom_ker[src_addr] : 32'd0;
    assign src_wgt = (int'(src_addr) < IMG_LEN) ? rom_wgt[src_addr] : 32'd0;

    // scoreboard
    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];      // expected Img words, in stream order

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    // shared state between main flow and monitor
    int          start_cyc = -10;
    int          resp_mode = RESP_NONE;
    int          resp_param = 0;
    logic [31:0] resp_out = '0;
    logic [1:0]  exp_opt = '0;
    logic        exp_cg = 1'b0;
    bit          mon_reset = 1'b0;
    bit          in_run = 1'b0;
    bit          waiting = 1'b0;
    int          run_len = 0;
    int          last_iv = 0;
    int          idx;
    logic [31:0] e_img;
    logic        ov;

    // Monitor + SNN responder: samples each cycle 2 time units after the
    // edge and drives out_valid/out for that same cycle.
    always @(posedge clk) begin
        #2;
        ov = 1'b0;
        if (mon_reset) begin
            exp_q.delete();
            in_run    = 1'b0;
            waiting   = 1'b0;
            run_len   = 0;
            mon_reset = 1'b0;
        end else if (rst_n) begin
            if (in_valid) begin
                if (!in_run) begin
                    in_run  = 1'b1;
                    run_len = 0;
                    check("first_iv_cycle", 64'(cyc), 64'(start_cyc + 1));
                end
                idx = run_len;
                if (exp_q.size() == 0) begin
                    check("img_queue_empty", 64'(1), 64'(0));
                end else begin
                    e_img = exp_q.pop_front();
                    check("img", 64'(Img), 64'(e_img));
                end
                if (idx < IMG_LEN) begin
                    check("kernel", 64'(Kernel), 64'((idx < KER_LEN) ? rom_ker[idx] : 32'd0));
                    check("weight", 64'(Weight), 64'((idx < WGT_LEN) ? rom_wgt[idx] : 32'd0));
                end
                check("opt", 64'(Opt), 64'((idx == 0) ? exp_opt : 2'd0));
                if (resp_mode == RESP_EARLY && idx == resp_param) ov = 1'b1;
                run_len++;
            end else if (in_run) begin
                in_run  = 1'b0;
                last_iv = cyc - 1;
                waiting = (resp_mode == RESP_DELAY);
                check("iv_len", 64'(run_len), 64'(IMG_LEN));
                check("post_iv_data", 64'(Img | Kernel | Weight), 64'(0));
                check("post_iv_opt", 64'(Opt), 64'(0));
            end
            if (waiting && cyc == last_iv + resp_param) begin
                ov      = 1'b1;
                waiting = 1'b0;
            end
            check("cg_en", 64'(cg_en), 64'(busy & exp_cg));
        end
        out_valid = ov;
        out_data  = ov ? resp_out : $urandom;
    end

    task automatic fill_rom(input bit nominal);
        for (int i = 0; i < IMG_LEN; i++) begin
            rom_img[i] = nominal ? 32'(i)         : $urandom;
            rom_ker[i] = nominal ? 32'(32'h100 + i) : ($urandom | 32'h1);
            rom_wgt[i] = nominal ? 32'(32'h200 + i) : ($urandom | 32'h1);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_valid"}, 64'(in_valid), 64'(0));
        check({tag, "_data"},     64'(Img | Kernel | Weight), 64'(0));
        check({tag, "_opt"},      64'(Opt), 64'(0));
        check({tag, "_cg_en"},    64'(cg_en), 64'(0));
        check({tag, "_busy"},     64'(busy), 64'(0));
        check({tag, "_done"},     64'(done), 64'(0));
        check({tag, "_pass"},     64'(pass), 64'(0));
        check({tag, "_err"},      64'(err_code), 64'(0));
        check({tag, "_result"},   64'(result), 64'(0));
        check({tag, "_latency"},  64'(latency), 64'(0));
        check({tag, "_src_addr"}, 64'(src_addr), 64'(0));
    endtask

    // Issue start for one pattern (leaves main flow at +1 in cycle S+1).
    task automatic launch(input int mode, input int param, input logic [31:0] outv,
                          input logic [31:0] expv, input logic [1:0] opt, input logic cg,
                          input bit nominal);
        fill_rom(nominal);
        exp_q.delete();
        for (int i = 0; i < IMG_LEN; i++) exp_q.push_back(rom_img[i]);
        resp_mode  = mode;
        resp_param = param;
        resp_out   = outv;
        exp_opt    = opt;
        exp_cg     = cg;
        @(posedge clk); #1;
        start     = 1'b1;
        cfg_opt   = opt;
        cfg_cg_en = cg;
        exp_out   = expv;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_pattern(input string tag, input int mode, input int param,
                               input logic [31:0] outv, input logic [31:0] expv,
                               input logic [1:0] opt, input logic cg, input bit nominal);
        int       last_cyc, exp_done, exp_lat;
        logic [1:0]  exp_err;
        logic        exp_pass;
        logic [31:0] exp_res;
        bit          seen;
        launch(mode, param, outv, expv, opt, cg, nominal);
        // Reference: stream occupies cycles S+1..S+IMG_LEN, report follows
        // the deciding cycle by one.
        last_cyc = start_cyc + IMG_LEN;
        exp_lat  = 0;
        exp_res  = '0;
        exp_pass = 1'b0;
        if (mode == RESP_EARLY) begin
            exp_done = last_cyc + 1;
            exp_err  = 2'd3;
        end else if (mode == RESP_DELAY && param <= LAT_MAX) begin
            exp_done = last_cyc + param + 1;
            exp_res  = outv;
            exp_lat  = param;
            exp_pass = (outv == expv);
            exp_err  = (outv == expv) ? 2'd0 : 2'd1;
        end else begin
            exp_done = last_cyc + LAT_MAX + 1;
            exp_err  = 2'd2;
        end
        seen = 1'b0;
        for (int n = 0; n < 3000 && !seen; n++) begin
            @(posedge clk); #3;
            if (done) seen = 1'b1;
        end
        check({tag, "_done_seen"}, 64'(seen), 64'(1));
        if (seen) begin
            check({tag, "_done_cycle"}, 64'(cyc), 64'(exp_done));
            check({tag, "_pass"},       64'(pass), 64'(exp_pass));
            check({tag, "_err_code"},   64'(err_code), 64'(exp_err));
            check({tag, "_result"},     64'(result), 64'(exp_res));
            check({tag, "_latency"},    64'(latency), 64'(exp_lat));
            check({tag, "_busy_rep"},   64'(busy), 64'(1));
            @(posedge clk); #3;
            check({tag, "_done_pulse"}, 64'(done), 64'(0));
            check({tag, "_busy_idle"},  64'(busy), 64'(0));
            check({tag, "_err_held"},   64'(err_code), 64'(exp_err));
            check({tag, "_res_held"},   64'(result), 64'(exp_res));
        end
    endtask

    task automatic run_reset_abort();
        int s, dones;
        logic [1:0]  o;
        logic [31:0] ev;
        o  = 2'($urandom_range(1, 3));
        ev = $urandom;
        launch(RESP_NONE, 0, ev, ev, o, 1'b1, 1'b0);
        s = start_cyc;
        // second start while busy, with different settings
        repeat (2) @(posedge clk);
        #1;
        start     = 1'b1;
        cfg_opt   = ~o;
        cfg_cg_en = 1'b0;
        exp_out   = ~ev;
        @(posedge clk); #1;
        start = 1'b0;
        while (cyc != s + 1 + 30) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        mon_reset = 1'b1;
        rst_n     = 1'b1;
        #2;
        check_reset_outputs("abort");
        dones = 0;
        repeat (100) begin
            @(posedge clk); #3;
            if (done || in_valid) dones++;
        end
        check("abort_no_activity", 64'(dones), 64'(0));
    endtask

    initial begin
        logic [31:0] ev, ovv;
        int d;
        rst_n     = 1'b0;
        start     = 1'b0;
        cfg_opt   = '0;
        cfg_cg_en = 1'b0;
        exp_out   = '0;
        out_valid = 1'b0;
        out_data  = '0;
        fill_rom(1'b1);
        repeat (3) @(posedge clk);
        #3;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        run_pattern("nominal",  RESP_DELAY, 50, 32'h3F80_0000, 32'h3F80_0000, 2'd2, 1'b1, 1'b1);
        run_pattern("mismatch", RESP_DELAY, 50, 32'h3F80_0001, 32'h3F80_0000, 2'd2, 1'b1, 1'b1);
        run_pattern("timeout",  RESP_NONE,  0,  32'h0, $urandom, 2'd1, 1'b0, 1'b0);
        run_pattern("protocol", RESP_EARLY, 10, $urandom, $urandom, 2'd3, 1'b1, 1'b0);
        run_reset_abort();
        run_pattern("clean",    RESP_DELAY, 7,  32'hCAFE_F00D, 32'hCAFE_F00D, 2'd1, 1'b1, 1'b0);
        ev = $urandom;
        run_pattern("boundary", RESP_DELAY, LAT_MAX, ev, ev, 2'd0, 1'b1, 1'b0);
        ev = $urandom;
        run_pattern("min_lat",  RESP_DELAY, 1, ev, ev, 2'd2, 1'b0, 1'b0);
        for (int r = 0; r < 4; r++) begin
            d   = $urandom_range(1, 200);
            ev  = $urandom;
            ovv = ($urandom_range(0, 1) == 1) ? ev : (ev ^ (32'd1 << $urandom_range(0, 31)));
            run_pattern("random", RESP_DELAY, d, ovv, ev, 2'($urandom_range(0, 3)),
                        1'($urandom_range(0, 1)), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: got no finish, expected finish before 1000000");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
